set_gen: RTL and testbench
==========================

# set_gen

Parametrised successor to the fixed 8×8, two-circle lattice-point counter.
- Scans a GRID×GRID lattice, one point per clock, and tests each point against up to three circles.
- Counts the points that satisfy the selected set-combination mode and reports the count with a one-cycle `valid` pulse.
- Sits in the same geometry/set-coverage datapath and replaces the multi-cycle-per-point block with a 3-stage pipelined scan.

## Interface
- `GRID`, 8: lattice side; coordinates run 1..GRID (GRID ≤ 2^CW − 1).
- `CW`, 4: coordinate field width.
- `RW`, 4: radius field width.
- `CNTW`, $clog2(GRID*GRID+1): candidate width (derived; 7 at defaults).
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  start request; sampled only while `busy`=0.
- `central`  in  6*CW  {Ax,Ay,Bx,By,Cx,Cy}, MSB first.
- `radius`  in  3*RW  {rA,rB,rC}, MSB first.
- `mode`  in  3  set-combination select.
- `busy`  out  1  scan in progress.
- `valid`  out  1  one-cycle pulse: `candidate` is final.
- `candidate`  out  CNTW  point count.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - On a clock edge with `en`=1, latch `central`, `radius` and `mode`; clear `candidate` to 0.
  - Reset X=Y=1, set `busy`=1 and go to SCAN.
- SCAN:
  - Issue point (X,Y) into the pipeline every cycle; X increments fastest.
  - At X=GRID: X←1, Y←Y+1.
  - Issuing (GRID,GRID) moves the FSM to DRAIN.
- Pipeline:
  - S1: signed differences dx = X − cx and dy = Y − cy, each CW+1 bits, per circle.
  - S2: dx² + dy² (2*CW+3 bits, no overflow) compared with r² (2*RW bits, zero-extended). The point is inside when sum ≤ r²; the result is registered as flags inA, inB, inC.
  - S3: `candidate` += sel(flags).
- DRAIN: 2 cycles until the last point has been accumulated, then DONE.
- DONE: for exactly 1 cycle, `valid`=1 and `busy`=0; then IDLE.
- Mode selection (latched at start):
  - 000: A
  - 001: A∧B
  - 010: A⊕B
  - 011: exactly two of {A,B,C}
  - 100: A∧B∧C
  - 101–111: A⊕B
- `en` while `busy`=1 is ignored.
- Inputs may change freely after the start edge.
- `candidate` holds its value after `valid` until the next accepted start.
- Centre coordinates of 0 or > GRID are legal; out-of-grid parts of a circle are simply not counted.
- r=0 counts only the centre point, if it lies on the grid.

## Timing
- Reset values: `busy`=0, `valid`=0, `candidate`=0; FSM in IDLE, X=Y=1.
- Start edge E0: `busy`=1 after E0; point (1,1) is issued on the cycle after E0.
- Latency: `valid` rises at edge E0 + GRID² + 3 (67 at default GRID); `busy` falls at that same edge.
- Back-to-back: `en`=1 in the cycle where `valid`=1 is accepted at the next edge. Minimum start-to-start spacing is GRID² + 4 cycles.
- Reset mid-scan: all outputs return to their reset values immediately (asynchronous). The pipeline is flushed and no `valid` is produced.
- Counter saturation is impossible because CNTW covers GRID².

## Configuration
- `SET_THREE_CIRCLE_EN` defined:
  - Circle C datapath is present.
  - Modes 011 and 100 behave as listed.
- Macro undefined:
  - Circle C is not built; bits `central[2*CW-1:0]` and `radius[RW-1:0]` are ignored.
  - Modes 011 and 100 fall into the default A⊕B.
  - Port widths are unchanged.

## Test plan
- Default parameters, mode 000, A=(4,4), rA=2 → `valid` at E0+67 with `candidate`=13; `busy` high for exactly 67 cycles.
- Mode 001 with A=B=(4,4), r=2 → 13. Same circles with mode 010 → 0.
- Corner clipping: mode 000, A=(1,1), rA=2 → 6. Mode 010 with A=(8,8) rA=0 and B=(1,1) rB=0 → 2.
- Full cover: mode 000, A=(4,4), rA=15 → 64. Then start again with `en` held high through the `valid` cycle; the second run starts on the next edge, and `candidate` clears to 0 after that edge.
- Three circles, macro defined: A=B=C=(4,4), r=2. Mode 100 → 13; mode 011 → 0. With the macro undefined, mode 100 → 0 (A⊕B).
- Robustness:
  - Pulse `en` mid-scan → no effect on the count.
  - Assert `rst` at cycle 30 of a scan → `busy`/`valid`/`candidate` go to 0 at once.
  - A fresh start after reset gives the correct count (13 for the first scenario).

Source files
------------

// File: rtl/set_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | set_gen: pipelined GRIDxGRID lattice scan counting points that match a    |
// | set combination of up to three circles. Circle C: SET_THREE_CIRCLE_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module set_gen #(
   parameter int GRID = 8,
   parameter int CW   = 4,
   parameter int RW   = 4,
   parameter int CNTW = $clog2(GRID*GRID+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [6*CW-1:0]   central,
   input  logic [3*RW-1:0]   radius,
   input  logic [2:0]        mode,
   output logic              busy,
   output logic              valid,
   output logic [CNTW-1:0]   candidate
);

`ifdef SET_THREE_CIRCLE_EN
   localparam int c_NC = 3;
`else
   localparam int c_NC = 2;
`endif
   localparam int        c_SW   = 2*CW+3;
   localparam logic [CW-1:0] c_GMAX = CW'(GRID);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          r_state, w_next;
   logic [CW-1:0]   r_x, r_y;
   logic [1:0]      r_drain;
   logic [2:0]      r_mode;
   logic            r_v1, r_v2;
   logic [CNTW-1:0] r_cand;
   logic [c_NC-1:0] w_flags;
   logic            w_start, w_last, w_sel;
   logic            w_a, w_b, w_c;

   assign w_start = en && (r_state == IDLE || r_state == DONE);
   assign w_last  = (r_x == c_GMAX) && (r_y == c_GMAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      valid  = 1'b0;
      case (r_state)
         IDLE:  if (w_start) w_next = SCAN;
         SCAN:  begin
            busy = 1'b1;
            if (w_last) w_next = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (r_drain == 2'd2) w_next = DONE;
         end
         DONE:  begin
            valid  = 1'b1;
            w_next = w_start ? SCAN : IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Scan counters, pipeline valid bits and the accumulator
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x     <= CW'(1);
         r_y     <= CW'(1);
         r_drain <= 2'd0;
         r_mode  <= 3'd0;
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_cand  <= '0;
      end else begin
         r_v1    <= (r_state == SCAN);
         r_v2    <= r_v1;
         r_drain <= (r_state == DRAIN) ? r_drain + 2'd1 : 2'd0;
         if (w_start) begin
            r_x    <= CW'(1);
            r_y    <= CW'(1);
            r_mode <= mode;
            r_cand <= '0;
         end else begin
            if (r_state == SCAN) begin
               if (r_x == c_GMAX) begin
                  r_x <= CW'(1);
                  r_y <= r_y + CW'(1);
               end else begin
                  r_x <= r_x + CW'(1);
               end
            end
            if (r_v2 && w_sel) r_cand <= r_cand + CNTW'(1);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < c_NC; gi++) begin : g_circle
         logic [CW-1:0]          r_cx, r_cy;
         logic [RW-1:0]          r_r;
         logic signed [CW:0]     r_dx, r_dy;
         logic                   r_in;
         logic signed [c_SW-1:0] w_dxe, w_dye, w_sum;
         logic [2*RW-1:0]        w_r2;

         assign w_dxe = c_SW'(r_dx);
         assign w_dye = c_SW'(r_dy);
         assign w_sum = w_dxe*w_dxe + w_dye*w_dye;
         assign w_r2  = {{RW{1'b0}}, r_r} * {{RW{1'b0}}, r_r};
         assign w_flags[gi] = r_in;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_cx <= '0;
               r_cy <= '0;
               r_r  <= '0;
               r_dx <= '0;
               r_dy <= '0;
               r_in <= 1'b0;
            end else begin
               if (w_start) begin
                  r_cx <= central[(6-2*gi)*CW-1 -: CW];
                  r_cy <= central[(5-2*gi)*CW-1 -: CW];
                  r_r  <= radius[(3-gi)*RW-1 -: RW];
               end
               if (r_state == SCAN) begin
                  r_dx <= $signed({1'b0, r_x}) - $signed({1'b0, r_cx});
                  r_dy <= $signed({1'b0, r_y}) - $signed({1'b0, r_cy});
               end
               r_in <= ({{(2*RW){1'b0}}, w_sum} <= {{c_SW{1'b0}}, w_r2});
            end
         end
      end
   endgenerate

   assign w_a = w_flags[0];
   assign w_b = w_flags[1];
`ifdef SET_THREE_CIRCLE_EN
   assign w_c = w_flags[2];
`else
   logic w_unused;
   assign w_c      = 1'b0;
   assign w_unused = ^{central[2*CW-1:0], radius[RW-1:0], w_c};
`endif

   always_comb begin
      w_sel = w_a ^ w_b;
      case (r_mode)
         3'b000: w_sel = w_a;
         3'b001: w_sel = w_a & w_b;
         3'b010: w_sel = w_a ^ w_b;
`ifdef SET_THREE_CIRCLE_EN
         3'b011: w_sel = (w_a & w_b & ~w_c) | (w_a & ~w_b & w_c) | (~w_a & w_b & w_c);
         3'b100: w_sel = w_a & w_b & w_c;
`endif
         default: w_sel = w_a ^ w_b;
      endcase
   end

   assign candidate = r_cand;

endmodule
`default_nettype wire

// File: tb/tb_set_gen.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for set_gen: directed scans, expected counts queued at start,
// a negedge monitor pops and compares whenever valid is seen.
module tb_set_gen;
   localparam int GRID = 8;
   localparam int CW   = 4;
   localparam int RW   = 4;
   localparam int CNTW = 7;
   localparam int LAT  = GRID*GRID + 3;

   logic            clk = 1'b0;
   logic            rst, en;
   logic [6*CW-1:0] central;
   logic [3*RW-1:0] radius;
   logic [2:0]      mode;
   logic            busy, valid;
   logic [CNTW-1:0] candidate;

   set_gen #(.GRID(GRID), .CW(CW), .RW(RW), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
      .mode(mode), .busy(busy), .valid(valid), .candidate(candidate)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cnt; int t0; } exp_t;
   exp_t q[$];
   exp_t e;
   int n_chk = 0, n_err = 0;
   int busy_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [6*CW-1:0] cen(input int ax, ay, bx, by, cx, cy);
      return {4'(ax), 4'(ay), 4'(bx), 4'(by), 4'(cx), 4'(cy)};
   endfunction

   function automatic logic [3*RW-1:0] rad(input int ra, rb, rc);
      return {4'(ra), 4'(rb), 4'(rc)};
   endfunction

   // Monitor
   always @(negedge clk) begin
      if (rst) busy_cnt = 0;
      else if (busy) busy_cnt++;
      else if (valid) begin
         if (q.size() == 0) check("unexpected_valid", 1, 0);
         else begin
            e = q.pop_front();
            check("count", int'(candidate), e.cnt);
            check("latency", cyc - e.t0, LAT);
            check("busy_len", busy_cnt, LAT);
         end
         busy_cnt = 0;
      end else busy_cnt = 0;
   end

   task automatic push_start(input int exp);
      exp_t x;
      x.cnt = exp;
      x.t0  = cyc;
      q.push_back(x);
      check("busy_after_start", int'(busy), 1);
      check("cand_cleared", int'(candidate), 0);
   endtask

   task automatic start(input logic [6*CW-1:0] c, input logic [3*RW-1:0] r,
                        input logic [2:0] m, input int exp);
      @(posedge clk); #1;
      central = c; radius = r; mode = m; en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      push_start(exp);
      central = $urandom; radius = $urandom; mode = 3'($urandom);
   endtask

   task automatic wait_valid(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < LAT + 20 && !seen; i++) begin
         @(negedge clk);
         if (valid) seen = 1'b1;
      end
      if (!seen) check({name, "_timeout"}, 0, 1);
   endtask

   task automatic run(input string name, input logic [6*CW-1:0] c,
                      input logic [3*RW-1:0] r, input logic [2:0] m, input int exp);
      start(c, r, m, exp);
      wait_valid(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; en = 1'b0; central = '0; radius = '0; mode = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_cand", int'(candidate), 0);
      rst = 1'b0;

      run("m0_circle",  cen(4,4,1,1,2,2), rad(2,15,15), 3'b000, 13);
      run("m1_and",     cen(4,4,4,4,1,1), rad(2,2,0),   3'b001, 13);
      run("m2_xor",     cen(4,4,4,4,1,1), rad(2,2,0),   3'b010, 0);
      run("corner",     cen(1,1,8,8,3,3), rad(2,0,1),   3'b000, 6);
      run("two_pts",    cen(8,8,1,1,4,4), rad(0,0,3),   3'b010, 2);
      run("m5_xor",     cen(4,4,1,1,4,4), rad(2,0,2),   3'b101, 14);
      run("ctr_zero",   cen(0,0,5,5,5,5), rad(2,1,1),   3'b000, 1);
      run("ctr_out",    cen(9,9,5,5,5,5), rad(2,1,1),   3'b000, 1);
`ifdef SET_THREE_CIRCLE_EN
      run("m4_and3",    cen(4,4,4,4,4,4), rad(2,2,2),   3'b100, 13);
`else
      run("m4_and3",    cen(4,4,4,4,4,4), rad(2,2,2),   3'b100, 0);
`endif
      run("m3_two",     cen(4,4,4,4,4,4), rad(2,2,2),   3'b011, 0);

      // Full cover then back-to-back restart with en held through valid
      @(posedge clk); #1;
      central = cen(4,4,1,1,1,1); radius = rad(15,0,0); mode = 3'b000; en = 1'b1;
      @(posedge clk); #1;
      push_start(64);
      central = cen(4,4,1,1,1,1); radius = rad(2,0,0);
      wait_valid("full_cover");
      @(posedge clk); #1;
      push_start(13);
      en = 1'b0;
      wait_valid("b2b");

      // en pulse mid-scan must be ignored
      start(cen(4,4,1,1,1,1), rad(2,0,0), 3'b000, 13);
      repeat (20) @(posedge clk);
      #1;
      central = cen(1,1,1,1,1,1); radius = rad(15,15,15); mode = 3'b001; en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      wait_valid("mid_en");

      // Asynchronous reset in the middle of a scan
      start(cen(4,4,1,1,1,1), rad(2,0,0), 3'b000, 13);
      repeat (29) @(posedge clk);
      #2;
      check("pre_rst_busy", int'(busy), 1);
      rst = 1'b1;
      #1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_valid", int'(valid), 0);
      check("midrst_cand", int'(candidate), 0);
      q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (LAT) @(posedge clk);
      run("after_rst", cen(4,4,1,1,1,1), rad(2,0,0), 3'b000, 13);

      repeat (5) @(posedge clk);
      check("queue_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
`default_nettype wire
